// File: rtl/chess_pkg.sv
// Shared types for the board controller: piece encoding, square/move records and the
// standard start position.
package chess_pkg;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        PAWN   = 3'd1,
        KNIGHT = 3'd2,
        BISHOP = 3'd3,
        ROOK   = 3'd4,
        QUEEN  = 3'd5,
        KING   = 3'd6
    } piece_t;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    typedef struct packed {
        piece_t ptype;
        logic   color;
        logic   moved;
    } square_t;

    typedef struct packed {
        logic [5:0] from;
        logic [5:0] to;
    } move_t;

    typedef square_t [7:0] row_t;

    // Index of the returned row is the column.
    function automatic row_t start_row(input logic [2:0] row);
        row_t r;
        logic c;
        c = (row <= 3'd1) ? BLACK : WHITE;
        for (int i = 0; i < 8; i++) begin
            r[i] = '{ptype: EMPTY, color: WHITE, moved: 1'b0};
        end
        if (row == 3'd0 || row == 3'd7) begin
            r[0].ptype = ROOK;
            r[1].ptype = KNIGHT;
            r[2].ptype = BISHOP;
            r[3].ptype = QUEEN;
            r[4].ptype = KING;
            r[5].ptype = BISHOP;
            r[6].ptype = KNIGHT;
            r[7].ptype = ROOK;
            for (int i = 0; i < 8; i++) begin
                r[i].color = c;
            end
        end else if (row == 3'd1 || row == 3'd6) begin
            for (int i = 0; i < 8; i++) begin
                r[i].ptype = PAWN;
                r[i].color = c;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/board_update_ctrl_if.sv
// Move request handshake plus commit status pulses between game logic and the board controller.
interface board_update_ctrl_if;
    import chess_pkg::*;

    logic       move_valid;
    logic       move_ready;
    logic [5:0] move_from;
    logic [5:0] move_to;
    logic       move_done;
    logic       move_err;
    logic       capture_valid;
    square_t    capture_piece;

    modport master (
        output move_valid, move_from, move_to,
        input  move_ready, move_done, move_err, capture_valid, capture_piece
    );

    modport slave (
        input  move_valid, move_from, move_to,
        output move_ready, move_done, move_err, capture_valid, capture_piece
    );

endinterface

// File: rtl/move_fifo.sv
// Fall-through request queue; head is visible on dout whenever empty is low.
module move_fifo
    import chess_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = move_t
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == FullCount);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_q];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din;
    end

endmodule

// File: rtl/board_update_ctrl.sv
// Owns the 8x8 board image and commits queued moves only during vertical blank so the
// display never shows a half-applied move.
module board_update_ctrl
    import chess_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_game,
    input  logic                frame_blank,
    board_update_ctrl_if.slave  bus,
    output square_t [7:0][7:0]  boardPos,
    output logic                busy
);

    localparam logic [2:0] StInit  = 3'd0;
    localparam logic [2:0] StIdle  = 3'd1;
    localparam logic [2:0] StRead  = 3'd2;
    localparam logic [2:0] StWrite = 3'd3;
    localparam logic [2:0] StClear = 3'd4;

    logic [2:0]         state_q;
    logic [2:0]         row_q;
    square_t [7:0][7:0] board_q;
    logic [5:0]         src_q;
    logic [5:0]         dst_q;
    logic [3:0]         src_top_q;
    square_t            dst_val_q;
    logic               done_q;
    logic               err_q;
    logic               cap_valid_q;
    square_t            cap_piece_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    move_t              fifo_din;
    move_t              fifo_dout;
    logic [3:0]         src_top;
    square_t            dst_rd;

    assign bus.move_ready = !fifo_full && (state_q != StInit) && !new_game;
    assign push           = bus.move_valid && bus.move_ready;
    assign pop            = (state_q == StIdle) && !fifo_empty && frame_blank && !new_game;
    assign fifo_din       = '{from: bus.move_from, to: bus.move_to};

    // Only type and color of the source travel with the move; moved is forced to 1.
    assign src_top = board_q[src_q[5:3]][src_q[2:0]][4:1];
    assign dst_rd  = board_q[dst_q[5:3]][dst_q[2:0]];

    move_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (move_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (new_game),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StInit;
            row_q       <= 3'd0;
            board_q     <= '0;
            src_q       <= 6'd0;
            dst_q       <= 6'd0;
            src_top_q   <= 4'd0;
            dst_val_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_piece_q <= '0;
        end else begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cap_valid_q <= 1'b0;
            if (new_game) begin
                state_q <= StInit;
                row_q   <= 3'd0;
            end else begin
                case (state_q)
                    StInit: begin
                        board_q[row_q] <= start_row(row_q);
                        row_q          <= row_q + 3'd1;
                        if (row_q == 3'd7) state_q <= StIdle;
                    end
                    StIdle: begin
                        if (pop) begin
                            src_q   <= fifo_dout.from;
                            dst_q   <= fifo_dout.to;
                            state_q <= StRead;
                        end
                    end
                    StRead: begin
                        src_top_q <= src_top;
                        dst_val_q <= dst_rd;
                        if (src_top[3:1] == EMPTY || src_q == dst_q) begin
                            err_q   <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            state_q <= StWrite;
                        end
                    end
                    StWrite: begin
                        board_q[dst_q[5:3]][dst_q[2:0]] <= {src_top_q, 1'b1};
                        if (dst_val_q.ptype != EMPTY) begin
                            cap_valid_q <= 1'b1;
                            cap_piece_q <= dst_val_q;
                        end
                        state_q <= StClear;
                    end
                    StClear: begin
                        board_q[src_q[5:3]][src_q[2:0]] <= '0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign boardPos          = board_q;
    assign busy              = (state_q != StIdle) || !fifo_empty;
    assign bus.move_done     = done_q;
    assign bus.move_err      = err_q;
    assign bus.capture_valid = cap_valid_q;
    assign bus.capture_piece = cap_piece_q;

endmodule

// File: tb/tb_board_update_ctrl.sv
// Directed bench for board_update_ctrl: start position, blank gating, capture, queue full,
// rejected moves, new_game abort and mid-operation reset.
module tb_board_update_ctrl;
    import chess_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               new_game;
    logic               frame_blank;
    square_t [7:0][7:0] board_pos;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int cap_cnt = 0;

    logic [2:0] back_type [8];

    board_update_ctrl_if bif ();

    board_update_ctrl #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .new_game    (new_game),
        .frame_blank (frame_blank),
        .bus         (bif),
        .boardPos    (board_pos),
        .busy        (busy)
    );

    always #10 clk = ~clk;

    function automatic logic [4:0] exp_start(input int r, input int c);
        logic [2:0] t;
        logic       col;
        col = (r <= 1) ? 1'b1 : 1'b0;
        if (r == 0 || r == 7) t = back_type[c];
        else if (r == 1 || r == 6) t = 3'd1;
        else return 5'd0;
        return {t, col, 1'b0};
    endfunction

    // Advance one clock, sample #1 after the edge and tally status pulses.
    task automatic step();
        @(posedge clk);
        #1;
        if (bif.move_done === 1'b1) done_cnt++;
        if (bif.move_err === 1'b1) err_cnt++;
        if (bif.capture_valid === 1'b1) cap_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_move(input logic [5:0] f, input logic [5:0] t, output bit ok);
        bit acc;
        ok = 1'b0;
        bif.move_from  = f;
        bif.move_to    = t;
        bif.move_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            acc = bif.move_ready;
            step();
            if (acc) ok = 1'b1;
        end
        bif.move_valid = 1'b0;
    endtask

    task automatic check_start_board(input string tag);
        int bad_col;
        for (int r = 0; r < 8; r++) begin
            bad_col = -1;
            for (int c = 0; c < 8; c++) begin
                if (bad_col < 0 && board_pos[r][c] !== exp_start(r, c)) bad_col = c;
            end
            checks++;
            if (bad_col >= 0) begin
                errors++;
                $display("FAIL %s row%0d col%0d got %h want %h", tag, r, bad_col,
                         board_pos[r][bad_col], exp_start(r, bad_col));
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        new_game = 1'b0;
        frame_blank = 1'b0;
        bif.move_valid = 1'b0;
        bif.move_from = 6'd0;
        bif.move_to = 6'd0;
        run(2);
        checks++;
        if (board_pos !== '0) begin
            errors++;
            $display("FAIL reset_board got %h want 0", board_pos);
        end
        checks++;
        if (busy !== 1'b1 || bif.move_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b ready=%b want busy=1 ready=0", busy,
                     bif.move_ready);
        end
        checks++;
        if (bif.move_done !== 1'b0 || bif.move_err !== 1'b0 || bif.capture_valid !== 1'b0 ||
            bif.capture_piece !== 5'd0) begin
            errors++;
            $display("FAIL reset_pulses done=%b err=%b cap=%b piece=%h want all 0",
                     bif.move_done, bif.move_err, bif.capture_valid, bif.capture_piece);
        end
        reset = 1'b0;
        step();
        bad = 0;
        for (int r = 1; r < 8; r++) begin
            for (int c = 0; c < 8; c++) if (board_pos[r][c] !== 5'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL init_window nonzero squares got %0d want 0", bad);
        end
        run(7);
        check_start_board("init");
        checks++;
        if (busy !== 1'b0 || bif.move_ready !== 1'b1) begin
            errors++;
            $display("FAIL init_done busy=%b ready=%b want busy=0 ready=1", busy,
                     bif.move_ready);
        end
    endtask

    task automatic test_blank_wait();
        bit ok;
        bit changed;
        frame_blank = 1'b0;
        done_cnt = 0;
        push_move(6'o64, 6'o44, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL blank_push accepted=0 want 1");
        end
        changed = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (board_pos[6][4] !== 5'h04 || board_pos[4][4] !== 5'h00) changed = 1'b1;
        end
        checks++;
        if (changed || done_cnt != 0) begin
            errors++;
            $display("FAIL blank_hold changed=%b done=%0d want 0 0", changed, done_cnt);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL blank_busy got %b want 1", busy);
        end
        frame_blank = 1'b1;
        run(3);
        checks++;
        if (board_pos[6][4] !== 5'h04 || bif.move_done !== 1'b0) begin
            errors++;
            $display("FAIL blank_early src=%h done=%b want 04 0", board_pos[6][4],
                     bif.move_done);
        end
        step();
        checks++;
        if (board_pos[4][4] !== 5'h05 || board_pos[6][4] !== 5'h00 || bif.move_done !== 1'b1)
        begin
            errors++;
            $display("FAIL blank_commit dst=%h src=%h done=%b want 05 00 1", board_pos[4][4],
                     board_pos[6][4], bif.move_done);
        end
        run(6);
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL blank_done_count got %0d want 1", done_cnt);
        end
        frame_blank = 1'b0;
    endtask

    task automatic test_capture();
        bit ok;
        frame_blank = 1'b1;
        done_cnt = 0;
        cap_cnt = 0;
        push_move(6'o73, 6'o13, ok);
        for (int i = 0; i < 20 && done_cnt == 0; i++) step();
        checks++;
        if (!ok || done_cnt != 1) begin
            errors++;
            $display("FAIL capture_commit accepted=%b done=%0d want 1 1", ok, done_cnt);
        end
        checks++;
        if (cap_cnt != 1 || bif.capture_piece !== 5'h06) begin
            errors++;
            $display("FAIL capture_piece pulses=%0d piece=%h want 1 06", cap_cnt,
                     bif.capture_piece);
        end
        checks++;
        if (board_pos[1][3] !== 5'h15 || board_pos[7][3] !== 5'h00) begin
            errors++;
            $display("FAIL capture_board dst=%h src=%h want 15 00", board_pos[1][3],
                     board_pos[7][3]);
        end
        frame_blank = 1'b0;
    endtask

    task automatic test_full();
        bit ok;
        bit all_ok;
        bit acc;
        bit accepted;
        int k;
        int t4;
        all_ok = 1'b1;
        frame_blank = 1'b0;
        for (int c = 0; c < 4; c++) begin
            push_move({3'd6, 3'(c)}, {3'd5, 3'(c)}, ok);
            if (!ok) all_ok = 1'b0;
        end
        checks++;
        if (!all_ok) begin
            errors++;
            $display("FAIL full_fill accepted_all=0 want 1");
        end
        bif.move_from = 6'o65;
        bif.move_to = 6'o55;
        bif.move_valid = 1'b1;
        #1;
        checks++;
        if (bif.move_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready got %b want 0", bif.move_ready);
        end
        run(3);
        checks++;
        if (bif.move_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_hold ready=%b busy=%b want 0 1", bif.move_ready, busy);
        end
        done_cnt = 0;
        accepted = 1'b0;
        t4 = 0;
        frame_blank = 1'b1;
        for (int i = 1; i <= 40 && done_cnt < 5; i++) begin
            acc = bif.move_valid && bif.move_ready;
            step();
            if (acc) begin
                bif.move_valid = 1'b0;
                accepted = 1'b1;
            end
            if (bif.move_done === 1'b1 && done_cnt <= 4) begin
                k = done_cnt;
                if (k == 4) t4 = i;
                checks++;
                if (board_pos[5][k-1] !== 5'h05 || board_pos[6][k-1] !== 5'h00 ||
                    (k < 4 && board_pos[6][k] !== 5'h04)) begin
                    errors++;
                    $display("FAIL full_order done#%0d dst=%h src=%h want 05 00", k,
                             board_pos[5][k-1], board_pos[6][k-1]);
                end
            end
        end
        bif.move_valid = 1'b0;
        checks++;
        if (t4 == 0 || t4 > 16) begin
            errors++;
            $display("FAIL full_latency four commits at cycle %0d want 1..16", t4);
        end
        checks++;
        if (!accepted || done_cnt != 5 || board_pos[5][5] !== 5'h05 ||
            board_pos[6][5] !== 5'h00) begin
            errors++;
            $display("FAIL full_fifth accepted=%b done=%0d dst=%h want 1 5 05", accepted,
                     done_cnt, board_pos[5][5]);
        end
        frame_blank = 1'b0;
    endtask

    task automatic test_err();
        bit ok;
        frame_blank = 1'b1;
        err_cnt = 0;
        done_cnt = 0;
        push_move(6'o33, 6'o44, ok);
        run(12);
        checks++;
        if (!ok || err_cnt != 1 || done_cnt != 0) begin
            errors++;
            $display("FAIL err_empty accepted=%b err=%0d done=%0d want 1 1 0", ok, err_cnt,
                     done_cnt);
        end
        checks++;
        if (board_pos[4][4] !== 5'h05 || board_pos[3][3] !== 5'h00 ||
            bif.capture_piece !== 5'h06) begin
            errors++;
            $display("FAIL err_empty_board dst=%h src=%h piece=%h want 05 00 06",
                     board_pos[4][4], board_pos[3][3], bif.capture_piece);
        end
        err_cnt = 0;
        push_move(6'o66, 6'o66, ok);
        run(12);
        checks++;
        if (!ok || err_cnt != 1 || done_cnt != 0 || board_pos[6][6] !== 5'h04) begin
            errors++;
            $display("FAIL err_same accepted=%b err=%0d done=%0d sq=%h want 1 1 0 04", ok,
                     err_cnt, done_cnt, board_pos[6][6]);
        end
        frame_blank = 1'b0;
    endtask

    task automatic test_new_game();
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        frame_blank = 1'b0;
        push_move(6'o67, 6'o57, ok);
        all_ok &= ok;
        push_move(6'o50, 6'o40, ok);
        all_ok &= ok;
        push_move(6'o51, 6'o41, ok);
        all_ok &= ok;
        checks++;
        if (!all_ok) begin
            errors++;
            $display("FAIL ng_fill accepted_all=0 want 1");
        end
        done_cnt = 0;
        err_cnt = 0;
        frame_blank = 1'b1;
        run(2);
        new_game = 1'b1;
        bif.move_from = 6'o65;
        bif.move_to = 6'o45;
        bif.move_valid = 1'b1;
        #1;
        checks++;
        if (bif.move_ready !== 1'b0) begin
            errors++;
            $display("FAIL ng_ready got %b want 0", bif.move_ready);
        end
        step();
        new_game = 1'b0;
        bif.move_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || bif.move_ready !== 1'b0) begin
            errors++;
            $display("FAIL ng_init busy=%b ready=%b want 1 0", busy, bif.move_ready);
        end
        run(8);
        checks++;
        if (busy !== 1'b0 || done_cnt != 0) begin
            errors++;
            $display("FAIL ng_flush busy=%b done=%0d want 0 0", busy, done_cnt);
        end
        check_start_board("new_game");
        run(10);
        checks++;
        if (done_cnt != 0 || err_cnt != 0) begin
            errors++;
            $display("FAIL ng_idle done=%0d err=%0d want 0 0", done_cnt, err_cnt);
        end
        frame_blank = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        frame_blank = 1'b1;
        done_cnt = 0;
        push_move(6'o64, 6'o44, ok);
        step();
        reset = 1'b1;
        step();
        checks++;
        if (board_pos !== '0 || busy !== 1'b1 || bif.move_ready !== 1'b0 ||
            bif.capture_piece !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid busy=%b ready=%b piece=%h want 1 0 00", busy,
                     bif.move_ready, bif.capture_piece);
        end
        reset = 1'b0;
        run(8);
        check_start_board("reset_mid");
        run(10);
        checks++;
        if (!ok || done_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_flush accepted=%b done=%0d busy=%b want 1 0 0", ok,
                     done_cnt, busy);
        end
        frame_blank = 1'b0;
    endtask

    initial begin
        back_type[0] = 3'd4;
        back_type[1] = 3'd2;
        back_type[2] = 3'd3;
        back_type[3] = 3'd5;
        back_type[4] = 3'd6;
        back_type[5] = 3'd3;
        back_type[6] = 3'd2;
        back_type[7] = 3'd4;
        test_reset();
        test_blank_wait();
        test_capture();
        test_full();
        test_err();
        test_new_game();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
